esc_pwm_generator: RTL and testbench

Four-channel ESC pulse generator on the drone's motor output side, the transmit-direction counterpart of the RC pulse-width receiver path. Takes four motor values from the flight-control path via a valid/ready handshake and emits four standard 1000–2000 us high-time pulses per fixed frame. All four channels share one frame timebase and update atomically at frame start. Includes a power-up arming hold and an optional update-loss failsafe.

---
 rtl/esc_pwm_generator_pkg.sv | 31 +++
 rtl/esc_pwm_generator_channel.sv | 35 +++
 rtl/esc_pwm_generator.sv | 193 +++++++++++++++++++
 tb/tb_esc_pwm_generator.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/esc_pwm_generator_pkg.sv
// Shared constants, state encoding and value-to-pulse mapping for the ESC pulse generator.
package esc_pwm_generator_pkg;

  localparam int unsigned PWM_VALUE_BIT_WIDTH = 8;
  localparam int unsigned ESC_PULSE_BIT_WIDTH = 11;

  typedef logic [ESC_PULSE_BIT_WIDTH-1:0] pulse_t;
  typedef logic [PWM_VALUE_BIT_WIDTH-1:0] motor_val_t;

  localparam pulse_t ESC_MIN_PULSE_US  = 11'd1000;
  localparam pulse_t ESC_PULSE_SPAN_US = 11'd1000;

  typedef enum logic [1:0] {
    ST_ARMING   = 2'd0,
    ST_RUN      = 2'd1,
    ST_FAILSAFE = 2'd2
  } esc_state_e;

  // 1000 us + 4 us per step, saturating at the 2000 us ceiling
  function automatic pulse_t value_to_pulse(input motor_val_t val);
    pulse_t scaled;
    scaled = {1'b0, val, 2'b00};
    if (scaled > ESC_PULSE_SPAN_US) begin
      scaled = ESC_PULSE_SPAN_US;
    end else begin
      scaled = scaled;
    end
    return scaled + ESC_MIN_PULSE_US;
  endfunction

endpackage

// File: rtl/esc_pwm_generator_channel.sv
// One ESC output channel: latches its pulse width at frame wrap and compares it
// against the shared frame counter to drive a registered pwm output.
module esc_pwm_channel
  import esc_pwm_generator_pkg::*;
#(
  parameter int unsigned CNT_W = 16
) (
  input  logic             us_clk,
  input  logic             resetn,
  input  logic             load,
  input  pulse_t           load_width,
  input  logic [CNT_W-1:0] cnt_next,
  output logic             pwm
);

  pulse_t width_r;
  logic   pwm_r;

  // pwm is high while the upcoming count is below the active width
  always_ff @(posedge us_clk or negedge resetn) begin
    if (!resetn) begin
      width_r <= ESC_MIN_PULSE_US;
      pwm_r   <= 1'b0;
    end else if (load) begin
      width_r <= load_width;
      pwm_r   <= 1'b1;
    end else begin
      width_r <= width_r;
      pwm_r   <= (cnt_next < CNT_W'(width_r));
    end
  end

  assign pwm = pwm_r;

endmodule

// File: rtl/esc_pwm_generator.sv
// Four-channel ESC pulse generator with arming hold and atomic frame-start update.
// Optional update-loss failsafe enabled by defining ESC_FAILSAFE_EN.
module esc_pwm_generator
  import esc_pwm_generator_pkg::*;
#(
  parameter int unsigned FRAME_PERIOD_US = 20000,
  parameter int unsigned ARM_FRAMES      = 50,
  parameter int unsigned FAILSAFE_FRAMES = 10
) (
  input  logic       us_clk,
  input  logic       resetn,
  input  motor_val_t motor1_val,
  input  motor_val_t motor2_val,
  input  motor_val_t motor3_val,
  input  motor_val_t motor4_val,
  input  logic       update_valid,
  output logic       update_ready,
  output logic       motor1_pwm,
  output logic       motor2_pwm,
  output logic       motor3_pwm,
  output logic       motor4_pwm,
  output logic       frame_start,
  output logic       armed,
  output logic       failsafe_active
);

  localparam int unsigned     CNT_W    = $clog2(FRAME_PERIOD_US);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FRAME_PERIOD_US - 1);
  localparam int unsigned     ARM_W    = $clog2(ARM_FRAMES + 1);
  localparam logic [ARM_W-1:0] ARM_DONE = ARM_W'(ARM_FRAMES);

  logic [CNT_W-1:0] frame_cnt_r, frame_cnt_nxt_s;
  logic             wrap_s, xfer_s;
  esc_state_e       state_r, state_nxt_s;
  logic [ARM_W-1:0] arm_cnt_r, arm_cnt_nxt_s;
  motor_val_t       vals_s [4];
  pulse_t           shadow_r [4];
  pulse_t           load_width_s [4];
  logic [3:0]       pwm_s;
  logic             ready_r, frame_start_r, armed_r;

  assign vals_s[0] = motor1_val;
  assign vals_s[1] = motor2_val;
  assign vals_s[2] = motor3_val;
  assign vals_s[3] = motor4_val;
  assign xfer_s    = update_valid & ready_r;

  // Frame timebase: the last count is the load cycle
  always_comb begin
    wrap_s = (frame_cnt_r == CNT_LAST);
    if (wrap_s) begin
      frame_cnt_nxt_s = {CNT_W{1'b0}};
    end else begin
      frame_cnt_nxt_s = frame_cnt_r + CNT_W'(1);
    end
  end

`ifdef ESC_FAILSAFE_EN
  localparam int unsigned     FS_W     = $clog2(FAILSAFE_FRAMES + 1);
  localparam logic [FS_W-1:0] FS_LIMIT = FS_W'(FAILSAFE_FRAMES);

  logic [FS_W-1:0] fs_cnt_r, fs_cnt_nxt_s;
  logic            xfer_seen_r, failsafe_r;

  // Consecutive frames ending without an accepted transfer, saturating
  always_comb begin
    fs_cnt_nxt_s = fs_cnt_r;
    if (wrap_s) begin
      if ((state_r == ST_ARMING) || xfer_seen_r) begin
        fs_cnt_nxt_s = {FS_W{1'b0}};
      end else if (fs_cnt_r != FS_LIMIT) begin
        fs_cnt_nxt_s = fs_cnt_r + FS_W'(1);
      end else begin
        fs_cnt_nxt_s = fs_cnt_r;
      end
    end else begin
      fs_cnt_nxt_s = fs_cnt_r;
    end
  end

  // Loss counter and per-frame transfer flag
  always_ff @(posedge us_clk or negedge resetn) begin
    if (!resetn) begin
      fs_cnt_r    <= {FS_W{1'b0}};
      xfer_seen_r <= 1'b0;
      failsafe_r  <= 1'b0;
    end else begin
      fs_cnt_r    <= fs_cnt_nxt_s;
      xfer_seen_r <= wrap_s ? 1'b0 : (xfer_seen_r | xfer_s);
      failsafe_r  <= (state_nxt_s == ST_FAILSAFE);
    end
  end

  assign failsafe_active = failsafe_r;
`else
  assign failsafe_active = 1'b0;
`endif

  // Mode transitions only happen at the frame wrap
  always_comb begin
    state_nxt_s   = state_r;
    arm_cnt_nxt_s = arm_cnt_r;
    if (wrap_s) begin
      case (state_r)
        ST_ARMING: begin
          if (arm_cnt_r == ARM_DONE) begin
            state_nxt_s = ST_RUN;
          end else begin
            arm_cnt_nxt_s = arm_cnt_r + ARM_W'(1);
          end
        end
        ST_RUN: begin
`ifdef ESC_FAILSAFE_EN
          if (fs_cnt_nxt_s == FS_LIMIT) begin
            state_nxt_s = ST_FAILSAFE;
          end else begin
            state_nxt_s = ST_RUN;
          end
`else
          state_nxt_s = ST_RUN;
`endif
        end
        ST_FAILSAFE: begin
`ifdef ESC_FAILSAFE_EN
          if (xfer_seen_r) begin
            state_nxt_s = ST_RUN;
          end else begin
            state_nxt_s = ST_FAILSAFE;
          end
`else
          state_nxt_s = ST_ARMING;
`endif
        end
        default: state_nxt_s = ST_ARMING;
      endcase
    end else begin
      state_nxt_s = state_r;
    end
    for (int i = 0; i < 4; i++) begin
      load_width_s[i] = (state_nxt_s == ST_RUN) ? shadow_r[i] : ESC_MIN_PULSE_US;
    end
  end

  // Timebase, mode and registered status outputs
  always_ff @(posedge us_clk or negedge resetn) begin
    if (!resetn) begin
      frame_cnt_r   <= CNT_LAST;
      state_r       <= ST_ARMING;
      arm_cnt_r     <= {ARM_W{1'b0}};
      ready_r       <= 1'b0;
      frame_start_r <= 1'b0;
      armed_r       <= 1'b0;
    end else begin
      frame_cnt_r   <= frame_cnt_nxt_s;
      state_r       <= state_nxt_s;
      arm_cnt_r     <= arm_cnt_nxt_s;
      ready_r       <= (frame_cnt_nxt_s != CNT_LAST);
      frame_start_r <= wrap_s;
      armed_r       <= (state_nxt_s != ST_ARMING);
    end
  end

  // Shadow widths, last accepted transfer wins
  always_ff @(posedge us_clk or negedge resetn) begin
    if (!resetn) begin
      for (int i = 0; i < 4; i++) shadow_r[i] <= ESC_MIN_PULSE_US;
    end else if (xfer_s) begin
      for (int i = 0; i < 4; i++) shadow_r[i] <= value_to_pulse(vals_s[i]);
    end else begin
      for (int i = 0; i < 4; i++) shadow_r[i] <= shadow_r[i];
    end
  end

  for (genvar g = 0; g < 4; g++) begin : g_ch
    esc_pwm_channel #(.CNT_W(CNT_W)) u_ch (
      .us_clk     (us_clk),
      .resetn     (resetn),
      .load       (wrap_s),
      .load_width (load_width_s[g]),
      .cnt_next   (frame_cnt_nxt_s),
      .pwm        (pwm_s[g])
    );
  end

  assign update_ready = ready_r;
  assign frame_start  = frame_start_r;
  assign armed        = armed_r;
  assign motor1_pwm   = pwm_s[0];
  assign motor2_pwm   = pwm_s[1];
  assign motor3_pwm   = pwm_s[2];
  assign motor4_pwm   = pwm_s[3];

endmodule

// File: tb/tb_esc_pwm_generator.sv
// Self-checking bench for esc_pwm_generator: per-frame pulse widths checked against a
// queue of expected frames; covers arming, mapping, last-wins, load-cycle and reset.
module tb_esc_pwm_generator;

  localparam int P   = 2100;
  localparam int ARM = 2;
  localparam int FS  = 3;

  typedef struct packed {
    logic [3:0][10:0] w;
    logic             armed;
    logic             fs;
  } exp_t;

  typedef struct packed {
    logic [3:0][7:0]  v;
    logic [3:0][10:0] w;
  } vec_t;

  logic       us_clk = 1'b0;
  logic       resetn = 1'b0;
  logic [7:0] mval [4];
  logic       update_valid;
  logic       update_ready, frame_start, armed, failsafe_active;
  logic       motor1_pwm, motor2_pwm, motor3_pwm, motor4_pwm;
  logic [3:0] pwm_v;

  int   checks   = 0;
  int   failures = 0;
  exp_t exp_q[$];
  vec_t vecs [4];

  esc_pwm_generator #(
    .FRAME_PERIOD_US (P),
    .ARM_FRAMES      (ARM),
    .FAILSAFE_FRAMES (FS)
  ) dut (
    .us_clk          (us_clk),
    .resetn          (resetn),
    .motor1_val      (mval[0]),
    .motor2_val      (mval[1]),
    .motor3_val      (mval[2]),
    .motor4_val      (mval[3]),
    .update_valid    (update_valid),
    .update_ready    (update_ready),
    .motor1_pwm      (motor1_pwm),
    .motor2_pwm      (motor2_pwm),
    .motor3_pwm      (motor3_pwm),
    .motor4_pwm      (motor4_pwm),
    .frame_start     (frame_start),
    .armed           (armed),
    .failsafe_active (failsafe_active)
  );

  assign pwm_v = {motor4_pwm, motor3_pwm, motor2_pwm, motor1_pwm};

  always #5 us_clk = ~us_clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic exp_t mk_exp(input int w0, w1, w2, w3, input logic a, input logic f);
    exp_t e;
    e.w[0] = 11'(w0); e.w[1] = 11'(w1); e.w[2] = 11'(w2); e.w[3] = 11'(w3);
    e.armed = a;
    e.fs    = f;
    return e;
  endfunction

  function automatic vec_t mk_vec(input int a, b, c, d, w0, w1, w2, w3);
    vec_t r;
    r.v[0] = 8'(a); r.v[1] = 8'(b); r.v[2] = 8'(c); r.v[3] = 8'(d);
    r.w[0] = 11'(w0); r.w[1] = 11'(w1); r.w[2] = 11'(w2); r.w[3] = 11'(w3);
    return r;
  endfunction

  task automatic skip(input int n);
    repeat (n) @(negedge us_clk);
  endtask

  // One-cycle transfer; optionally records what the next frame should show
  task automatic send(input string tag, input logic [3:0][7:0] v, input bit do_push, input exp_t e);
    check({tag, "_ready"}, int'(update_ready), 1);
    for (int ch = 0; ch < 4; ch++) mval[ch] = v[ch];
    update_valid = 1'b1;
    if (do_push) exp_q.push_back(e);
    @(negedge us_clk);
    update_valid = 1'b0;
  endtask

  // Called on the first cycle of a frame; consumes exactly one frame
  task automatic measure_frame(input string tag);
    exp_t e;
    int   hi [4];
    int   lead [4];
    bit   run [4];
    if (exp_q.size() == 0) begin
      checks++;
      failures++;
      $display("FAIL %s_queue: got empty expected one entry", tag);
      skip(P);
    end else begin
      e = exp_q.pop_front();
      check({tag, "_frame_start"}, int'(frame_start), 1);
      check({tag, "_armed"}, int'(armed), int'(e.armed));
      check({tag, "_failsafe"}, int'(failsafe_active), int'(e.fs));
      for (int ch = 0; ch < 4; ch++) begin
        hi[ch] = 0; lead[ch] = 0; run[ch] = 1'b1;
      end
      for (int c = 0; c < P; c++) begin
        for (int ch = 0; ch < 4; ch++) begin
          if (pwm_v[ch] === 1'b1) hi[ch]++;
          if (run[ch] && (pwm_v[ch] === 1'b1)) lead[ch]++;
          else run[ch] = 1'b0;
        end
        @(negedge us_clk);
      end
      for (int ch = 0; ch < 4; ch++) begin
        check($sformatf("%s_ch%0d_width", tag, ch + 1), hi[ch], int'(e.w[ch]));
        check($sformatf("%s_ch%0d_from_start", tag, ch + 1), lead[ch], int'(e.w[ch]));
      end
    end
  endtask

  initial begin
    logic [3:0][7:0] v;
    update_valid = 1'b0;
    for (int ch = 0; ch < 4; ch++) mval[ch] = 8'd0;

    vecs[0] = mk_vec(0, 125, 200, 255, 1000, 1500, 1800, 2000);
    vecs[1] = mk_vec(1, 249, 250, 100, 1004, 1996, 2000, 1400);
    vecs[2] = mk_vec(50, 64, 175, 251, 1200, 1256, 1700, 2000);
    vecs[3] = mk_vec(255, 0, 128, 3, 2000, 1000, 1512, 1012);

    // Reset state
    skip(3);
    check("rst_pwm", int'(pwm_v), 0);
    check("rst_frame_start", int'(frame_start), 0);
    check("rst_armed", int'(armed), 0);
    check("rst_failsafe", int'(failsafe_active), 0);
    check("rst_ready", int'(update_ready), 0);

    // Arming: values sent in frame 1 must not appear until frame ARM+1
    resetn = 1'b1;
    @(negedge us_clk);
    check("first_ready", int'(update_ready), 1);
    for (int f = 0; f < ARM; f++) exp_q.push_back(mk_exp(1000, 1000, 1000, 1000, 1'b0, 1'b0));
    exp_q.push_back(mk_exp(1160, 1160, 1160, 1160, 1'b1, 1'b0));
    v = {8'd40, 8'd40, 8'd40, 8'd40};
    fork
      measure_frame("arm1");
      begin skip(5); send("arm_send", v, 1'b0, mk_exp(0, 0, 0, 0, 1'b0, 1'b0)); end
    join
    for (int f = 1; f < ARM; f++) measure_frame($sformatf("arm%0d", f + 1));

    // Mapping table: each frame measured while the next vector is sent
    for (int i = 0; i < 4; i++) begin
      fork
        measure_frame($sformatf("vec%0d_prev", i));
        begin
          skip(100);
          send($sformatf("vec%0d", i), vecs[i].v, 1'b1,
               mk_exp(vecs[i].w[0], vecs[i].w[1], vecs[i].w[2], vecs[i].w[3], 1'b1, 1'b0));
        end
      join
    end

    // Last transfer wins; transfer offered in the load cycle is refused
    fork
      measure_frame("vec3");
      begin
        skip(10);
        v = {8'd100, 8'd100, 8'd100, 8'd100};
        send("lw_first", v, 1'b0, mk_exp(0, 0, 0, 0, 1'b0, 1'b0));
        v = {8'd150, 8'd150, 8'd150, 8'd150};
        send("lw_second", v, 1'b1, mk_exp(1600, 1600, 1600, 1600, 1'b1, 1'b0));
        skip(P - 1 - 12);
        check("load_cycle_ready", int'(update_ready), 0);
        for (int ch = 0; ch < 4; ch++) mval[ch] = 8'd10;
        update_valid = 1'b1;
        @(negedge us_clk);
        update_valid = 1'b0;
      end
    join

    // Transfer at the second-to-last count lands in the very next frame
    fork
      measure_frame("last_wins");
      begin
        skip(P - 2);
        v = {8'd30, 8'd30, 8'd30, 8'd30};
        send("late", v, 1'b1, mk_exp(1120, 1120, 1120, 1120, 1'b1, 1'b0));
      end
    join
    measure_frame("late_applied");

    // Update loss: FS frames without transfers, then recovery
    exp_q.push_back(mk_exp(1120, 1120, 1120, 1120, 1'b1, 1'b0));
    exp_q.push_back(mk_exp(1120, 1120, 1120, 1120, 1'b1, 1'b0));
`ifdef ESC_FAILSAFE_EN
    exp_q.push_back(mk_exp(1000, 1000, 1000, 1000, 1'b1, 1'b1));
`else
    exp_q.push_back(mk_exp(1120, 1120, 1120, 1120, 1'b1, 1'b0));
`endif
    measure_frame("loss1");
    measure_frame("loss2");
    fork
      measure_frame("loss3");
      begin
        skip(50);
        v = {8'd200, 8'd200, 8'd200, 8'd200};
        send("recover", v, 1'b1, mk_exp(1800, 1800, 1800, 1800, 1'b1, 1'b0));
      end
    join
    measure_frame("recovered");

    // Asynchronous reset in the middle of a pulse
    skip(700);
    check("pre_reset_pwm", int'(pwm_v), 15);
    resetn = 1'b0;
    #1;
    check("midrst_pwm", int'(pwm_v), 0);
    check("midrst_armed", int'(armed), 0);
    check("midrst_ready", int'(update_ready), 0);
    skip(3);
    resetn = 1'b1;
    @(negedge us_clk);
    for (int f = 0; f < ARM; f++) exp_q.push_back(mk_exp(1000, 1000, 1000, 1000, 1'b0, 1'b0));
    exp_q.push_back(mk_exp(1000, 1000, 1000, 1000, 1'b1, 1'b0));
    for (int f = 0; f <= ARM; f++) measure_frame($sformatf("rearm%0d", f + 1));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
